// File: rtl/d_e_pipe_reg_if.sv
// ----------------------------------------------------------------------------
// d_e_pipe_reg_if
//   Bundle of the signals crossing the Decode->Execute pipeline register.
//
//   Valid semantics: d_valid / e_valid mark the stage as holding a real
//   instruction. There is no ready signal. Back-pressure is expressed only by
//   the hazard unit through stall_i, and flush_i kills the E stage. A field
//   accompanied by valid=0 is inert: downstream logic must not act on it.
//
//   master : decode side + hazard unit + CP0 (drives d_*, stall_i, flush_i;
//            observes e_*)
//   slave  : the pipeline register itself (consumes d_*, stall_i, flush_i;
//            drives e_*)
//
//   Signals
//     stall_i    hazard unit: hold D, insert a bubble into E
//     flush_i    CP0 exception/interrupt/eret taken: kill E contents
//     d_valid    D holds a real instruction
//     d_pc       D-stage PC
//     d_instr    D-stage instruction word
//     d_rs_data  forwarded GPR[rs]
//     d_rt_data  forwarded GPR[rt]
//     d_ext      extended immediate
//     d_excode   pending exception code (0 = none)
//     d_bd       D instruction sits in a branch delay slot
//     d_tnew     cycles until the D result is available, counted at D
//     e_*        registered copies for the E stage (e_tnew is Tnew seen at E)
// ----------------------------------------------------------------------------
interface d_e_pipe_reg_if #(
    parameter int EXC_W = 5
);
    logic             stall_i;
    logic             flush_i;

    logic             d_valid;
    logic [31:0]      d_pc;
    logic [31:0]      d_instr;
    logic [31:0]      d_rs_data;
    logic [31:0]      d_rt_data;
    logic [31:0]      d_ext;
    logic [EXC_W-1:0] d_excode;
    logic             d_bd;
    logic [1:0]       d_tnew;

    logic             e_valid;
    logic [31:0]      e_pc;
    logic [31:0]      e_instr;
    logic [31:0]      e_rs_data;
    logic [31:0]      e_rt_data;
    logic [31:0]      e_ext;
    logic [EXC_W-1:0] e_excode;
    logic             e_bd;
    logic [1:0]       e_tnew;

    modport master (
        output stall_i, flush_i,
        output d_valid, d_pc, d_instr, d_rs_data, d_rt_data, d_ext,
        output d_excode, d_bd, d_tnew,
        input  e_valid, e_pc, e_instr, e_rs_data, e_rt_data, e_ext,
        input  e_excode, e_bd, e_tnew
    );

    modport slave (
        input  stall_i, flush_i,
        input  d_valid, d_pc, d_instr, d_rs_data, d_rt_data, d_ext,
        input  d_excode, d_bd, d_tnew,
        output e_valid, e_pc, e_instr, e_rs_data, e_rt_data, e_ext,
        output e_excode, e_bd, e_tnew
    );
endinterface

// File: rtl/d_e_pipe_reg.sv
// ----------------------------------------------------------------------------
// d_e_pipe_reg
//   Decode->Execute pipeline register of the 5-stage MIPS core (with CP0
//   exceptions). Latches the decode-stage results for the E stage and
//   implements bubble insertion on stall and flush on exception/eret.
//
//   Ports
//     clk    in  rising-edge clock for all state
//     reset  in  synchronous, active-high reset
//     bus    d_e_pipe_reg_if.slave: stall_i, flush_i, d_* in; e_* out
//
//   Per-edge priority: reset > flush_i > stall_i > normal load.
//   Every output comes straight from a flop: one cycle D->E latency and no
//   combinational path from any input to any output.
// ----------------------------------------------------------------------------
module d_e_pipe_reg #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter int          EXC_W      = 5
) (
    input logic            clk,
    input logic            reset,
    d_e_pipe_reg_if.slave  bus
);

    logic             valid_q;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic [31:0]      rs_data_q;
    logic [31:0]      rt_data_q;
    logic [31:0]      ext_q;
    logic [EXC_W-1:0] excode_q;
    logic             bd_q;
    logic [1:0]       tnew_q;

    // One stage has elapsed by the time the instruction reaches E, so the
    // remaining Tnew drops by one. It saturates at zero: a result already
    // available at D must not turn into "3 cycles away" by wrapping.
    logic [1:0] tnew_dec;

    always_comb begin
        tnew_dec = 2'd0;
        if (bus.d_tnew != 2'd0) begin
            tnew_dec = bus.d_tnew - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            rs_data_q <= 32'd0;
            rt_data_q <= 32'd0;
            ext_q     <= 32'd0;
            excode_q  <= '0;
            bd_q      <= 1'b0;
            tnew_q    <= 2'd0;
        end else if (bus.flush_i) begin
            // Exception/eret taken: E is killed and points at the handler.
            // A concurrent stall is irrelevant because E is emptied anyway.
            valid_q   <= 1'b0;
            pc_q      <= HANDLER_PC;
            instr_q   <= 32'd0;
            rs_data_q <= 32'd0;
            rt_data_q <= 32'd0;
            ext_q     <= 32'd0;
            excode_q  <= '0;
            bd_q      <= 1'b0;
            tnew_q    <= 2'd0;
        end else if (bus.stall_i) begin
            // Bubble. PC and BD still follow D so that an interrupt landing
            // on the bubble reports the EPC/BD of the held instruction.
            valid_q   <= 1'b0;
            pc_q      <= bus.d_pc;
            instr_q   <= 32'd0;
            rs_data_q <= 32'd0;
            rt_data_q <= 32'd0;
            ext_q     <= 32'd0;
            excode_q  <= '0;
            bd_q      <= bus.d_bd;
            tnew_q    <= 2'd0;
        end else begin
            // Normal load. Fields are copied verbatim even when d_valid=0;
            // valid_q=0 marks them inert. Exception codes pass through
            // unchanged: this block never creates or masks them.
            valid_q   <= bus.d_valid;
            pc_q      <= bus.d_pc;
            instr_q   <= bus.d_instr;
            rs_data_q <= bus.d_rs_data;
            rt_data_q <= bus.d_rt_data;
            ext_q     <= bus.d_ext;
            excode_q  <= bus.d_excode;
            bd_q      <= bus.d_bd;
            tnew_q    <= tnew_dec;
        end
    end

    assign bus.e_valid   = valid_q;
    assign bus.e_pc      = pc_q;
    assign bus.e_instr   = instr_q;
    assign bus.e_rs_data = rs_data_q;
    assign bus.e_rt_data = rt_data_q;
    assign bus.e_ext     = ext_q;
    assign bus.e_excode  = excode_q;
    assign bus.e_bd      = bd_q;
    assign bus.e_tnew    = tnew_q;

endmodule
